// File: rtl/facto_pkg.sv
// facto_pkg: shared types and constants for the factorial request controller.
// Holds the FSM encoding, operand width and default operand limit.
package facto_pkg;

  localparam int W = 8;
  localparam int MAX_X_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    RSP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
    logic         tmo;
  } rsp_t;

endpackage

// File: rtl/facto_req_if.sv
// facto_req_if: request, core and response signals of facto_req.
// slave is the controller side, master the host/core side.
interface facto_req_if;
  import facto_pkg::*;

  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] req_x_i;
  logic         start_o;
  logic [W-1:0] x_o;
  logic         done_i;
  logic [W-1:0] fi_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] rsp_data_o;
  logic         rsp_ovf_o;
  logic         rsp_tmo_o;
  logic         busy_o;

  modport slave (
    input  req_valid_i,
    input  req_x_i,
    input  done_i,
    input  fi_i,
    input  rsp_ready_i,
    output req_ready_o,
    output start_o,
    output x_o,
    output rsp_valid_o,
    output rsp_data_o,
    output rsp_ovf_o,
    output rsp_tmo_o,
    output busy_o
  );

  modport master (
    output req_valid_i,
    output req_x_i,
    output done_i,
    output fi_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  start_o,
    input  x_o,
    input  rsp_valid_o,
    input  rsp_data_o,
    input  rsp_ovf_o,
    input  rsp_tmo_o,
    input  busy_o
  );

endinterface

// File: rtl/facto_wdog.sv
// facto_wdog: cycle watchdog for the core handshake.
// expired is high during the LIMIT-th enabled cycle after clr.
module facto_wdog #(
  parameter int LIMIT = 255,
  parameter int CW    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en & (cnt_q == LIM);

endmodule

// File: rtl/facto_req.sv
// facto_req: valid/ready front end for the four-phase factorial core.
// Optional watchdog enabled by defining FACTO_REQ_TIMEOUT_EN.
module facto_req
  import facto_pkg::*;
#(
  parameter int MAX_X      = MAX_X_DEF,
  parameter int TMO_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  facto_req_if.slave  bus
);

  localparam logic [W-1:0] MAX_XV = W'(MAX_X);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] x_q;
  logic [W-1:0] x_d;
  rsp_t         rsp_q;
  rsp_t         rsp_d;
  logic         start_q;
  logic         rdy_q;
  logic         vld_q;
  logic         busy_q;
  logic         accept;
  logic         tmo_hit;

  assign accept = (state_q == IDLE)
                & bus.req_valid_i
                & rdy_q;

`ifdef FACTO_REQ_TIMEOUT_EN
  logic wd_en;

  assign wd_en = (state_q == REQ)
               | (state_q == REL);

  facto_wdog #(
    .LIMIT (TMO_CYCLES)
  ) u_wdog (
    .clk     (CLK),
    .rst     (RST),
    .clr     (accept),
    .en      (wd_en),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d = bus.req_x_i;
          if (bus.req_x_i > MAX_XV) begin
            rsp_d   = '{data: '0, ovf: 1'b1, tmo: 1'b0};
            state_d = RSP;
          end else begin
            rsp_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.done_i) begin
          rsp_d.data = bus.fi_i;
          state_d    = REL;
        end else if (tmo_hit) begin
          rsp_d   = '{data: '0, ovf: 1'b0, tmo: 1'b1};
          state_d = RSP;
        end
      end
      REL: begin
        if (!bus.done_i) begin
          state_d = RSP;
        end else if (tmo_hit) begin
          rsp_d   = '{data: '0, ovf: 1'b0, tmo: 1'b1};
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next state so they line up with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      rsp_q   <= '0;
      start_q <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rsp_q   <= rsp_d;
      start_q <= (state_d == REQ);
      rdy_q   <= (state_d == IDLE) & ~bus.done_i;
      vld_q   <= (state_d == RSP);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.req_ready_o = rdy_q;
  assign bus.start_o     = start_q;
  assign bus.x_o         = x_q;
  assign bus.rsp_valid_o = vld_q;
  assign bus.rsp_data_o  = rsp_q.data;
  assign bus.rsp_ovf_o   = rsp_q.ovf;
  assign bus.rsp_tmo_o   = rsp_q.tmo;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_facto_req.sv
// tb_facto_req: randomized bench for facto_req with a behavioural core.
// Define FACTO_REQ_TIMEOUT_EN to exercise the watchdog path.
module tb_facto_req;
  import facto_pkg::*;

  localparam int MAXX = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  facto_req_if bus();

  facto_req #(
    .MAX_X      (MAXX),
    .TMO_CYCLES (255)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_fact(input int x);
    int r;
    if (x > MAXX) return 0;
    r = 1;
    for (int i = 2; i <= x; i++) r = r * i;
    return r;
  endfunction

  // Core stand-in: fixed table, programmable latency, can be silenced.
  int  ftab [6] = '{1, 1, 2, 6, 24, 120};
  bit  core_en  = 1'b1;
  int  core_lat = 2;
  int  lat_cnt  = 0;

  always @(negedge CLK) begin
    if (!bus.start_o) begin
      bus.done_i = 1'b0;
      bus.fi_i   = 8'h00;
      lat_cnt    = 0;
    end else if (core_en && !bus.done_i) begin
      if (lat_cnt >= core_lat) begin
        bus.done_i = 1'b1;
        bus.fi_i   = (bus.x_o < 6) ? 8'(ftab[bus.x_o]) : 8'hee;
      end else begin
        lat_cnt++;
      end
    end
  end

  int       cyc = 0;
  int       acc_cyc = 0;
  int       xfer_cyc = 0;
  int       starts = 0;
  int       start_cyc = 0;
  int       viol = 0;
  logic     prev_start = 1'b0;
  logic [7:0] prev_x = 8'h00;

  always @(posedge CLK) begin
    if (bus.req_valid_i && bus.req_ready_o) acc_cyc = cyc;
    if (bus.rsp_valid_o && bus.rsp_ready_i) xfer_cyc = cyc;
    cyc++;
  end

  always @(negedge CLK) begin
    if (bus.start_o && !prev_start) begin
      starts++;
      start_cyc = cyc;
    end
    if (bus.start_o && prev_start && bus.x_o !== prev_x) viol++;
    if (bus.start_o && bus.rsp_valid_o) viol++;
    prev_start = bus.start_o;
    prev_x     = bus.x_o;
  end

  bit rdy_hi = 1'b0;

  task automatic send(input logic [7:0] x);
    int n;
    n = 0;
    @(negedge CLK);
    bus.req_valid_i = 1'b1;
    bus.req_x_i     = x;
    while (!bus.req_ready_o && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("send_ready", n < 500, 1);
    @(posedge CLK);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic recv(input string tag, input int x, input int hold);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    @(negedge CLK);
    while (!bus.rsp_valid_o && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_valid"}, n < 1000, 1);
    check({tag, "_data"}, bus.rsp_data_o, ref_fact(x));
    check({tag, "_ovf"}, bus.rsp_ovf_o, x > MAXX);
    check({tag, "_tmo"}, bus.rsp_tmo_o, 0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        if (!bus.rsp_valid_o || bus.req_ready_o ||
            bus.rsp_data_o !== 8'(ref_fact(x))) bad++;
      end
      check({tag, "_hold"}, bad, 0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge CLK);
    #1 bus.rsp_ready_i = rdy_hi;
  endtask

  initial begin
    int s0;
    int bad;
    int n;
    int x;
    bus.req_valid_i = 1'b0;
    bus.req_x_i     = 8'h00;
    bus.rsp_ready_i = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_ready", bus.req_ready_o, 0);
    check("rst_start", bus.start_o, 0);
    check("rst_valid", bus.rsp_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", bus.req_ready_o, 1);

    s0 = starts;
    send(8'd4);
    recv("x4", 4, 0);
    check("x4_starts", starts - s0, 1);

    rdy_hi = 1'b1;
    bus.rsp_ready_i = 1'b1;
    send(8'd0);
    recv("b2b_x0", 0, 0);
    send(8'd5);
    check("b2b_gap", acc_cyc - xfer_cyc, 1);
    recv("b2b_x5", 5, 0);

    s0 = starts;
    send(8'd6);
    recv("ovf6", 6, 0);
    send(8'd255);
    recv("ovf255", 255, 0);
    check("ovf_starts", starts - s0, 0);

    rdy_hi = 1'b0;
    bus.rsp_ready_i = 1'b0;
    send(8'd3);
    recv("hold3", 3, 10);
    @(negedge CLK);
    check("hold3_released", bus.rsp_valid_o, 0);

    for (int i = 0; i < 24; i++) begin
      x        = int'($urandom_range(0, 9));
      core_lat = int'($urandom_range(0, 6));
      send(8'(x));
      recv("rand", x, int'($urandom_range(0, 3)));
    end
    core_lat = 2;

    core_en = 1'b0;
    bus.rsp_ready_i = 1'b0;
    send(8'd4);
`ifdef FACTO_REQ_TIMEOUT_EN
    n = 0;
    while (!bus.rsp_valid_o && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_valid", bus.rsp_valid_o, 1);
    check("tmo_flag", bus.rsp_tmo_o, 1);
    check("tmo_data", bus.rsp_data_o, 0);
    check("tmo_ovf", bus.rsp_ovf_o, 0);
    check("tmo_start", bus.start_o, 0);
    check("tmo_latency", cyc - start_cyc, 255);
    bus.rsp_ready_i = 1'b1;
    @(posedge CLK);
    #1 bus.rsp_ready_i = 1'b0;
`else
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!bus.busy_o || bus.rsp_valid_o) bad++;
    end
    check("hang_busy", bad, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    #2 RST = 1'b0;
`endif
    core_en = 1'b1;

    core_lat = 30;
    send(8'd4);
    n = 0;
    while (!bus.start_o && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("mid_start_seen", bus.start_o, 1);
    #2 RST = 1'b1;
    #1;
    check("mid_start_async", bus.start_o, 0);
    check("mid_busy", bus.busy_o, 0);
    @(negedge CLK);
    #2 RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid_o) bad++;
    end
    check("mid_no_rsp", bad, 0);
    core_lat = 2;
    send(8'd4);
    recv("after_rst", 4, 0);

    check("protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/facto_req.md
# facto_req

Request-side controller for the factorial core's start/done handshake. It accepts 8-bit operands on a valid/ready request port and drives the core's `start_i`/`X` inputs. It then waits for the core's `Done` and captures `fi_out`, returning the result on a valid/ready response port. It sits between a command source (host register file or sequencer) and the factorial core, and it keeps out-of-range operands from reaching the 8-bit core.

## Interface
- MAX_X, 5, largest operand issued to the core (5! = 120 is the largest factorial that fits in 8 bits)
- TMO_CYCLES, 255, watchdog limit in cycles; used only when FACTO_REQ_TIMEOUT_EN is defined
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-high
- req_valid_i  in  1  request operand valid
- req_ready_o  out  1  controller can accept a request
- req_x_i  in  8  operand
- start_o  out  1  to core `start_i`
- x_o  out  8  to core `X`
- done_i  in  1  from core `Done`
- fi_i  in  8  from core `fi_out`
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  8  factorial result; 0 on error
- rsp_ovf_o  out  1  operand > MAX_X; the core was not started
- rsp_tmo_o  out  1  watchdog expired; constant 0 when the macro is off
- busy_o  out  1  state != IDLE

## Operation
- The core handshake is four-phase: `start_o` rises, the core raises `done_i`, `start_o` falls, the core drops `done_i`.
- `x_o` is held stable for the whole time `start_o` is high.
- FSM states: IDLE, REQ, REL, RSP.
- IDLE:
  - `req_ready_o = ~done_i`. A stale Done blocks acceptance.
  - On `req_valid_i & req_ready_o`, `req_x_i` is latched.
  - If the operand is > MAX_X: go to RSP with `ovf=1`, data 0. `start_o` never rises.
  - Otherwise go to REQ.
- REQ: `start_o = 1` and `x_o` = latched operand. On `done_i = 1`, capture `fi_i` into the response register and go to REL.
- REL: `start_o = 0`. On `done_i = 0`, go to RSP.
- RSP: `rsp_valid_o = 1`. Data and flags are held stable until `rsp_ready_i`, then go to IDLE.
- Operand 0 is issued normally; the core returns 1.
- Every output is registered. Reset values: `req_ready_o`=0 while RST is asserted, then `~done_i` once in IDLE. All other outputs are 0 and the state is IDLE.
- Reset mid-operation: the state returns to IDLE immediately and `start_o` drops asynchronously. Any in-flight result is lost, and no response is produced.

## Timing
- A request accepted at edge k raises `start_o` in the cycle after edge k.
- `done_i` sampled high at edge m: `fi_i` is captured at edge m and `start_o` is low after edge m.
- `done_i` sampled low at edge n: `rsp_valid_o` is high after edge n.
- Minimum overhead beyond core latency is 3 cycles (accept, release, response).
- Overflow path: request accepted at edge k, `rsp_valid_o` high after edge k.
- The response handshake and `rsp_ready_i` held permanently high: the next request can be accepted one cycle after the response transfers.
- No request is accepted while busy (one outstanding operation maximum).

## Configuration
- `FACTO_REQ_TIMEOUT_EN` defined:
  - An 8-bit+ counter clears on entry to REQ and increments every cycle in REQ and REL.
  - When it reaches TMO_CYCLES, the FSM goes to RSP with `tmo=1`, data 0, and `start_o` low.
  - After that, IDLE still waits for `done_i = 0` before accepting a request.
- Not defined: no counter is built, `rsp_tmo_o` is tied to 0, and REQ/REL wait indefinitely.

## Structure
- Shared package `facto_pkg` holds:
  - the state encoding (IDLE=0, REQ=1, REL=2, RSP=3)
  - operand/result width 8
  - the default MAX_X constant
- Sub-module `facto_wdog` holds the watchdog counter (clear, enable, expired). It is instantiated only under `FACTO_REQ_TIMEOUT_EN`.

## Test plan
- Request X=4 with the real factorial core: one `start_o` assertion, then a response with data 24, ovf=0, tmo=0, and `start_o` low before the response.
- X=0 then X=5 back-to-back with `rsp_ready_i`=1: responses 1 then 120 in order, with no overlap of `start_o`.
- X=6 and X=255: an immediate response with ovf=1 and data 0; `start_o` stays 0 throughout.
- Hold `rsp_ready_i`=0 for 10 cycles after a response to X=3: data stays 6, `req_ready_o` stays 0, and the response transfers once ready rises.
- Stub core that never asserts Done, with the macro defined and TMO_CYCLES=255: a tmo=1, data 0 response exactly 255 cycles after `start_o` rises. With the macro off: no response, `busy_o` stays 1.
- Assert RST for 1 cycle during REQ for X=4: `start_o` goes to 0 asynchronously and no response is produced. A new X=4 request then returns 24.
